// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter. Each cycle it picks the next fetch address:
// sequential (PC+1, word addressed, wraps at 2^32), a taken conditional
// branch, an unconditional jump, or a hold. It also signals a pipeline flush
// after a redirect and supports halt/resume. A redirect that arrives while
// the pipeline is stalled is parked in a pending register, so it is not lost.
//
// Optional feature: define PC_SEQ_RAS_EN to add a return-address stack with
// call/ret inputs. Without the macro those ports and the stack do not exist.
//
// Parameters
//   RESET_PC      PC value loaded on reset.
//   FLUSH_CYCLES  cycles flush is held after a redirect (1..7).
//   RAS_DEPTH     return-address stack entries (PC_SEQ_RAS_EN only; 2..16,
//                 power of 2).
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   stall          in   hold request from the hazard unit
//   branch         in   conditional branch resolved in EX this cycle
//   alu_flag[3:0]  in   ALU flag vector from EX
//   cond_mask[3:0] in   branch taken when alu_flag == cond_mask
//   branch_target  in   branch destination
//   jump_sel       in   unconditional jump resolved in EX this cycle
//   jump_target    in   jump destination
//   halt_req       in   stop fetching
//   resume         in   leave HALT
//   call, ret      in   (PC_SEQ_RAS_EN only) push return address / return
//   pc_out         out  current fetch address
//   pc_valid       out  pc_out is a real fetch this cycle
//   flush          out  kill younger instructions in IF/ID
//   halted         out  sequencer is in HALT
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [3:0]  alu_flag,
  input  logic [3:0]  cond_mask,
  input  logic [31:0] branch_target,
  input  logic        jump_sel,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
`ifdef PC_SEQ_RAS_EN
  input  logic        call,
  input  logic        ret,
`endif
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush,
  output logic        halted
);

  // Elaboration-time parameter sanity checks.
  if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("pc_sequencer: FLUSH_CYCLES must be in 1..7");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0)
  begin : g_bad_ras_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of 2 in 2..16");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;

  logic        taken_br;
  logic        redirect;
  logic [31:0] target;
  logic        accept;     // a redirect is taken up in RUN this cycle

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [31:0]      ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;           // index of the top entry
  logic [PTR_W:0]   ras_cnt_q, ras_cnt_d; // number of live entries
  logic [31:0]      ras_top;
  logic             ret_sel;
  logic             push, pop;
`endif

  // ---------------------------------------------------------------------------
  // Redirect decode. Priority: taken branch > ret (RAS build) > jump.
  // ---------------------------------------------------------------------------
  assign taken_br = branch && (alu_flag == cond_mask);

`ifdef PC_SEQ_RAS_EN
  assign ret_sel  = ret && !taken_br;
  assign ras_top  = (ras_cnt_q == '0) ? RESET_PC : ras_q[sp_q];
  assign redirect = taken_br || ret || jump_sel;
  assign target   = taken_br ? branch_target :
                    ret      ? ras_top       : jump_target;
`else
  assign redirect = taken_br || jump_sel;
  assign target   = taken_br ? branch_target : jump_target;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    unique case (state_q)
      S_RUN: begin
        // pc_valid_q is low in RUN only for the first cycle after reset:
        // that edge just arms fetch at RESET_PC without advancing.
        if (pc_valid_q) begin
          if (redirect) begin
            accept = 1'b1;
            if (stall) begin
              pend_d  = target;
              state_d = S_PEND;
            end else begin
              pc_d    = target;
              cnt_d   = FLUSH_INIT;
              state_d = S_FLUSH;
            end
          end else if (halt_req) begin
            state_d = S_HALT;
          end else if (!stall) begin
            pc_d = pc_q + 32'd1;
          end
        end
      end

      S_PEND: begin
        // New redirects are ignored: only one may be outstanding.
        if (!stall) begin
          pc_d    = pend_q;
          cnt_d   = FLUSH_INIT;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        // Fixed length: stall, redirects and halt_req have no effect here.
        if (cnt_q <= 3'd1) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_HALT: begin
        if (resume) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase

    // Outputs are registered: derive them from the state being entered.
    pc_valid_d = (state_d == S_RUN);
    flush_d    = (state_d == S_FLUSH);
    halted_d   = (state_d == S_HALT);
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      cnt_q      <= '0;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // ---------------------------------------------------------------------------
  // Return-address stack: circular, so a push when full overwrites the
  // oldest entry. Push and pop together replace the top entry.
  // ---------------------------------------------------------------------------
  assign push = accept && call;
  assign pop  = accept && ret_sel;

  always_comb begin
    ras_d     = ras_q;
    sp_d      = sp_q;
    ras_cnt_d = ras_cnt_q;

    if (push && pop) begin
      ras_d[sp_q] = pc_q + 32'd1;
      if (ras_cnt_q == '0) begin
        ras_cnt_d = {{PTR_W{1'b0}}, 1'b1};
      end
    end else if (push) begin
      sp_d        = sp_q + 1'b1;
      ras_d[sp_d] = pc_q + 32'd1;
      if (ras_cnt_q != RAS_FULL) begin
        ras_cnt_d = ras_cnt_q + 1'b1;
      end
    end else if (pop && ras_cnt_q != '0) begin
      sp_d      = sp_q - 1'b1;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  // NOTE: the stack contents are architecturally cleared on reset, so this
  // array is reset like ordinary flops rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
      sp_q      <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_q     <= ras_d;
      sp_q      <= sp_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end
`endif

  assign pc_out   = pc_q;
  assign pc_valid = pc_valid_q;
  assign flush    = flush_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (default build). A behavioural model
// tracks the architectural PC plus "flush cycles left", a pending-redirect
// queue and a halted flag; a compare process checks all outputs against it
// after every rising edge. Directed scenarios add literal expectations, then
// a randomized phase exercises interactions.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FC       = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [3:0]  alu_flag = '0;
  logic [3:0]  cond_mask = '0;
  logic [31:0] branch_target = '0;
  logic        jump_sel = 1'b0;
  logic [31:0] jump_target = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC     (RESET_PC),
    .FLUSH_CYCLES (FC),
    .RAS_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .alu_flag      (alu_flag),
    .cond_mask     (cond_mask),
    .branch_target (branch_target),
    .jump_sel      (jump_sel),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .halted        (halted)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc;
  bit          m_warm;       // first edge after reset has happened
  bit          m_halted;
  int          m_flush_left; // flush cycles still to come
  logic [31:0] m_pend[$];    // at most one parked redirect

  task automatic model_reset();
    m_pc         = RESET_PC;
    m_warm       = 1'b0;
    m_halted     = 1'b0;
    m_flush_left = 0;
    m_pend.delete();
  endtask

  function automatic bit m_valid();
    return m_warm && !m_halted && (m_flush_left == 0) && (m_pend.size() == 0);
  endfunction

  task automatic model_step();
    bit          tb_taken;
    logic [31:0] tgt;
    if (!m_warm) begin
      m_warm = 1'b1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_pend.size() != 0) begin
      if (!stall) begin
        m_pc         = m_pend.pop_front();
        m_flush_left = FC;
      end
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else begin
      tb_taken = branch && (alu_flag == cond_mask);
      if (tb_taken || jump_sel) begin
        tgt = tb_taken ? branch_target : jump_target;
        if (stall) begin
          m_pend.push_back(tgt);
        end else begin
          m_pc         = tgt;
          m_flush_left = FC;
        end
      end else if (halt_req) begin
        m_halted = 1'b1;
      end else if (!stall) begin
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: advance the model on each edge, check #1 later.
  always begin
    @(posedge clk);
    if (reset) begin
      model_step();
      #1;
      check("pc_out",   pc_out,   m_pc);
      check("pc_valid", pc_valid, m_valid());
      check("flush",    flush,    m_flush_left > 0);
      check("halted",   halted,   m_halted);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall    = 1'b0;
    branch   = 1'b0;
    jump_sel = 1'b0;
    halt_req = 1'b0;
    resume   = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    jump_sel    = 1'b1;
    jump_target = addr;
    step();
    jump_sel = 1'b0;
    repeat (FC) step();
    check("jump_to_pc",    pc_out,   addr);
    check("jump_to_valid", pc_valid, 1'b1);
  endtask

  initial begin
    model_reset();
    // Reset state
    #2;
    check("rst_pc",     pc_out,   RESET_PC);
    check("rst_valid",  pc_valid, 1'b0);
    check("rst_flush",  flush,    1'b0);
    check("rst_halted", halted,   1'b0);

    // Release: pc 0,0,1,2,3
    step();
    reset = 1'b1;
    step();
    check("rel_e1_pc",    pc_out,   32'd0);
    check("rel_e1_valid", pc_valid, 1'b1);
    step(); check("rel_e2_pc", pc_out, 32'd1);
    step(); check("rel_e3_pc", pc_out, 32'd2);
    step(); check("rel_e4_pc", pc_out, 32'd3);
    repeat (7) step();
    check("seq_pc10", pc_out, 32'd10);

    // Taken branch at pc=10 to 0x40
    branch        = 1'b1;
    alu_flag      = 4'b0100;
    cond_mask     = 4'b0100;
    branch_target = 32'h40;
    step();
    clear_inputs();
    check("br_pc",     pc_out,   32'h40);
    check("br_flush1", flush,    1'b1);
    check("br_valid1", pc_valid, 1'b0);
    step();
    check("br_flush2", flush,    1'b1);
    step();
    check("br_flush3", flush,    1'b0);
    check("br_valid3", pc_valid, 1'b1);
    check("br_pc3",    pc_out,   32'h40);
    step();
    check("br_next",   pc_out,   32'h41);

    // Not-taken branch: sequential, no flush
    branch    = 1'b1;
    alu_flag  = 4'b0001;
    cond_mask = 4'b0010;
    step();
    clear_inputs();
    check("nt_pc",    pc_out, 32'h42);
    check("nt_flush", flush,  1'b0);

    // Mismatched branch plus jump at pc=20
    jump_to(32'd20);
    branch      = 1'b1;
    alu_flag    = 4'b1000;
    cond_mask   = 4'b0001;
    jump_sel    = 1'b1;
    jump_target = 32'h80;
    step();
    clear_inputs();
    check("jmp_pc",    pc_out, 32'h80);
    check("jmp_flush", flush,  1'b1);
    repeat (FC) step();

    // Taken branch and jump together: branch wins
    branch        = 1'b1;
    alu_flag      = 4'b0011;
    cond_mask     = 4'b0011;
    branch_target = 32'h200;
    jump_sel      = 1'b1;
    jump_target   = 32'h300;
    step();
    clear_inputs();
    check("both_pc", pc_out, 32'h200);
    repeat (FC) step();

    // Redirect during stall parks in pending
    jump_to(32'd20);
    stall       = 1'b1;
    jump_sel    = 1'b1;
    jump_target = 32'h100;
    step();
    jump_sel = 1'b0;
    check("pend1_pc",    pc_out,   32'd20);
    check("pend1_valid", pc_valid, 1'b0);
    check("pend1_flush", flush,    1'b0);
    step();
    check("pend2_pc", pc_out, 32'd20);
    step();
    check("pend3_pc",    pc_out,   32'd20);
    check("pend3_valid", pc_valid, 1'b0);
    stall = 1'b0;
    step();
    check("pend_go_pc",    pc_out, 32'h100);
    check("pend_go_flush", flush,  1'b1);
    repeat (FC) step();
    check("pend_run_valid", pc_valid, 1'b1);

    // Halt at pc=5 for 10 cycles, then resume
    jump_to(32'd5);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_halted", halted,   1'b1);
    check("halt_valid",  pc_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_hold_pc", pc_out, 32'd5);
      check("halt_hold",    halted, 1'b1);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_valid",  pc_valid, 1'b1);
    check("resume_pc",     pc_out,   32'd5);
    check("resume_halted", halted,   1'b0);
    step();
    check("resume_next", pc_out, 32'd6);

    // Wrap at 2^32
    jump_to(32'hFFFF_FFFF);
    step();
    check("wrap_pc", pc_out, 32'd0);

    // Asynchronous reset in the middle of a flush
    jump_sel    = 1'b1;
    jump_target = 32'h77;
    step();
    jump_sel = 1'b0;
    check("arst_pre_flush", flush, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_pc",     pc_out,   RESET_PC);
    check("arst_valid",  pc_valid, 1'b0);
    check("arst_flush",  flush,    1'b0);
    check("arst_halted", halted,   1'b0);
    step();
    reset = 1'b1;
    step();
    check("arst_rel_pc",    pc_out,   RESET_PC);
    check("arst_rel_valid", pc_valid, 1'b1);

    // Randomized phase, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      stall         = ($urandom_range(0, 99) < 25);
      branch        = ($urandom_range(0, 99) < 20);
      alu_flag      = 4'($urandom_range(0, 3));
      cond_mask     = 4'($urandom_range(0, 3));
      branch_target = $urandom();
      jump_sel      = ($urandom_range(0, 99) < 10);
      jump_target   = (n % 97 == 0) ? 32'hFFFF_FFFE : $urandom();
      halt_req      = ($urandom_range(0, 99) < 5);
      resume        = ($urandom_range(0, 99) < 30);
      step();
    end
    clear_inputs();
    repeat (FC + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences the next-address path: sequential fetch (PC+1, word-addressed), conditional branch on ALU flag match, unconditional jump, stall hold, pipeline flush and halt/resume.
- Sits between the EX-stage branch/jump resolution and the IF-stage instruction memory address port.
- Buffers a redirect that arrives during a stall so it is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush is held after a redirect (1..7).
- RAS_DEPTH, 4, return-address stack entries (used only with RAS_EN; power of 2, 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard-unit hold request; PC must not advance.
- branch  in  1  conditional branch resolved in EX this cycle.
- alu_flag  in  4  ALU flag vector from EX.
- cond_mask  in  4  branch condition; taken when alu_flag == cond_mask.
- branch_target  in  32  branch destination.
- jump_sel  in  1  unconditional jump resolved in EX this cycle.
- jump_target  in  32  jump destination.
- halt_req  in  1  stop fetching.
- resume  in  1  leave HALT.
- pc_out  out  32  current fetch address.
- pc_valid  out  1  pc_out is a real fetch this cycle.
- flush  out  1  kill younger instructions in IF/ID.
- halted  out  1  sequencer is in HALT.

Behaviour:
- Reset (reset=0, async): pc_out=RESET_PC, pc_valid=0, flush=0, halted=0, state=RUN, pending latch cleared, flush counter=0. On the first rising edge after release, pc_valid=1 with pc_out still RESET_PC.
- redirect = taken_br | jump_sel, where taken_br = branch & (alu_flag==cond_mask). target = taken_br ? branch_target : jump_target. Branch wins over jump when both are asserted.
- Not-taken branch (branch=1, no match, jump_sel=0): sequential, no flush.
- PC arithmetic: PC+1 mod 2^32. 32'hFFFF_FFFF wraps to 0.
- States:
  - RUN: pc_valid=1.
    - redirect & !stall: pc_out<=target; go to FLUSH with counter=FLUSH_CYCLES.
    - redirect & stall: latch target into pending; go to PEND.
    - !redirect & !stall: pc_out<=pc_out+1.
    - stall: hold.
    - halt_req (no redirect): go to HALT; pc held.
  - PEND: pc_valid=0, pc held. Redirect inputs are ignored (only one redirect can be outstanding). On the first cycle with stall=0: pc_out<=pending; go to FLUSH.
  - FLUSH: flush=1, pc_valid=0, pc held at the new target. Counter decrements each cycle. When it reaches 1, go to RUN next edge. Redirects and halt_req are ignored while flushing; stall does not extend FLUSH.
  - HALT: halted=1, pc_valid=0, pc held. resume=1 goes to RUN next edge; pc_out unchanged, so fetch restarts at the held PC.
- Priority in RUN: redirect > halt_req > stall > sequential. A halt_req that coincides with a redirect is dropped; the requester must hold it.
- flush and halted are registered outputs. Latency from redirect to first valid fetch at target = FLUSH_CYCLES+1 edges (no stall).
- Reset mid-FLUSH/PEND/HALT: immediate return to the reset values, pending discarded.

Optional Feature:
- Macro: PC_SEQ_RAS_EN.
- With the macro defined:
  - Adds inputs call (1) and ret (1).
  - call with redirect, accepted in RUN: pushes pc_out+1.
  - ret: redirects to the top of stack and pops it; ret is treated as a jump (below taken branch, above jump_sel).
  - Push when full overwrites the oldest entry (circular).
  - Pop when empty returns RESET_PC.
  - Push and pop in the same cycle: replace the top entry.
  - Stack is cleared on reset.
- Without the macro: the ports and stack are absent; behaviour is exactly as above.

Test Plan:
- Reset release with stall=0: pc_out 0,0,1,2,3 on successive edges; pc_valid 0→1 after the first edge.
- pc=10, branch=1, alu_flag=4'b0100, cond_mask=4'b0100, branch_target=0x40 → pc_out=0x40 next edge; flush=1 for 2 cycles; pc_valid=1 on the third cycle; fetch 0x41 follows.
- pc=20, branch=1 with flag mismatch and jump_sel=1, jump_target=0x80 → pc=0x80 with flush. Branch taken and jump both asserted → branch_target is selected.
- stall=1 for 3 cycles with jump_sel pulse to 0x100 in stall cycle 1 → PEND, pc held at 20; stall drops → pc=0x100, then FLUSH.
- halt_req at pc=5 → halted=1, pc=5 held for 10 cycles; resume → pc_valid=1 at 5, then 6. pc=0xFFFF_FFFF sequential → 0.
- Async reset asserted mid-FLUSH (between edges) → outputs return to reset values immediately without a clock.
